div6by3_seq: RTL

//   Sequential restoring divider, the inverse operation of the team's 3-bit combinational multiplier.

---
 rtl/div6by3_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/div6by3_seq.sv
// -----------------------------------------------------------------------------
// div6by3_seq
//
// Sequential restoring divider: the inverse of the 3-bit combinational
// multiplier. It divides an unsigned DW-bit dividend by an unsigned VW-bit
// divisor and produces one quotient bit per clock. The default 6/3 sizing
// matches the multiplier's product/operand widths, so a multiply followed by a
// divide returns the original operands.
//
// Ports
//   clk          in   1    single clock, rising edge
//   rst          in   1    asynchronous, active-high reset
//   start        in   1    request; sampled only while busy is low
//   dividend     in   DW   unsigned dividend, captured on an accepted start
//   divisor      in   VW   unsigned divisor, captured on an accepted start
//   busy         out  1    high while an operation is in progress
//   done         out  1    one-cycle pulse: results valid
//   quotient     out  DW   unsigned quotient, held until the next completion
//   remainder    out  VW   unsigned remainder, held until the next completion
//   div_by_zero  out  1    set with done when divisor was 0, held with results
//
// Handshake: a request is taken at a rising edge where start=1 and busy=0.
// busy rises at that edge and falls at the edge that raises done. done is
// high for exactly one cycle, and busy and done are never high together. A
// start held high during the done cycle is accepted at the next edge. start
// while busy is ignored and the operand ports are not sampled.
//
// Timing: a non-zero divisor gives done in the cycle after edge E0+DW, where
// E0 is the accepting edge. A zero divisor skips the iteration. The FSM stays
// in IDLE and done, with div_by_zero set, follows one clock after E0.
// -----------------------------------------------------------------------------
module div6by3_seq #(
    parameter int DW = 6,
    parameter int VW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    // Iteration counter: counts 0..DW-1, one step per quotient bit.
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    // Operand and working registers.
    logic [DW-1:0] a_reg;   // dividend, shifted left so the next bit is the MSB
    logic [VW-1:0] b_reg;   // latched divisor
    logic [VW-1:0] r_reg;   // partial remainder between steps
    logic [DW-1:0] q_reg;   // quotient shift register
    logic [CW-1:0] cnt;
    logic          zpend;   // zero-divisor result due at the next edge

    // Combinational control and iteration datapath.
    logic          accept;
    logic          last_step;
    logic [VW:0]   r_shift; // R = {R, next dividend bit}, VW+1 bits wide
    logic          ge;
    logic [VW-1:0] r_sub;
    logic [VW-1:0] r_next;
    logic [DW:0]   q_ext;
    logic [DW-1:0] q_next;

    // ------------------------------------------------------------------
    // FSM: next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        accept     = 1'b0;
        last_step  = 1'b0;
        state_next = state;

        // busy is checked as well as IDLE, so a pending zero-divisor
        // result (IDLE, busy=1) cannot be overtaken by a new request.
        accept = start && (state == IDLE) && !busy;

        case (state)
            IDLE: begin
                if (accept && (divisor != '0)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                last_step = (cnt == LAST);
                if (last_step) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // One restoring step.
    // The stored remainder is always below the divisor, so it fits in VW
    // bits. Only the shifted value needs the extra bit, and that bit is used
    // only in the compare. Once the compare passes, the true difference is
    // below the divisor, so a VW-bit subtraction gives the exact result.
    // ------------------------------------------------------------------
    always_comb begin
        r_shift = {r_reg, a_reg[DW-1]};
        ge      = (r_shift >= {1'b0, b_reg});
        r_sub   = r_shift[VW-1:0] - b_reg;
        r_next  = ge ? r_sub : r_shift[VW-1:0];
        // The (DW+1)-bit concatenation also works when DW is 1.
        q_ext   = {q_reg, ge};
        q_next  = q_ext[DW-1:0];
    end

    // ------------------------------------------------------------------
    // FSM: state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers.
    // quotient, remainder and div_by_zero change only at completion or on
    // reset. The previous result stays visible while a new one is computed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            cnt         <= '0;
            zpend       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_reg <= dividend;
                b_reg <= divisor;
                r_reg <= '0;
                q_reg <= '0;
                cnt   <= '0;
                busy  <= 1'b1;
                zpend <= (divisor == '0);
            end else if (zpend) begin
                zpend       <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b1;
                div_by_zero <= 1'b1;
                quotient    <= '1;
                remainder   <= '0;
            end else if (state == RUN) begin
                r_reg <= r_next;
                q_reg <= q_next;
                a_reg <= a_reg << 1;
                cnt   <= cnt + 1'b1;
                if (last_step) begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= 1'b0;
                    quotient    <= q_next;
                    remainder   <= r_next;
                end
            end
        end
    end

endmodule
